mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port access controller between the pipelined CPU and the shared instruction/data memory.
- Arbitrates the fetch-stage port and the memory-stage port onto one memory port, so fetch and data accesses no longer collide in the same cycle.
- Freezes the whole pipeline with `stall` until every request present in a cycle has been serviced.
- Returns the results for all serviced requests together, in one release cycle.

Parameters:
- ADDR_W, 32, width of all address buses.
- DATA_W, 32, width of all data buses.
- READ_LAT, 1, memory read latency in cycles. Legal range 1..15; the latency counter is 4 bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch-stage read request.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction word.
- dm_rd  in  1  memory-stage load request.
- dm_wr  in  1  memory-stage store request.
- dm_addr  in  ADDR_W  data address (ALU result).
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load result.
- stall  out  1  pipeline freeze; when high the PC and all interstage registers hold.
- done  out  1  one-cycle release pulse; if_rdata/dm_rdata valid in this cycle.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after the read strobe.

Behaviour:
- Reset: one clock; asynchronous active-low reset `reset_n`.
  - Asserting reset_n low at any time, including mid-transaction, forces state IDLE.
  - All pending flags, latched addresses and wdata, if_rdata, dm_rdata and mem_* outputs are cleared to 0.
  - done=0. stall follows its combinational rule.
  - No memory strobe is issued in the cycle after reset_n deasserts.
- States: IDLE, DATA, WAIT_D, INST, WAIT_I, DONE.
- stall = (state==IDLE & (if_req|dm_rd|dm_wr)) | (state not in {IDLE, DONE}).
  - stall is combinational, so the pipeline never advances in the cycle a request first appears.
- IDLE:
  - If any request is present, latch pend_d=(dm_rd|dm_wr), op (write if dm_wr, else read), pend_i=if_req, both addresses and dm_wdata.
  - Next state: DATA if pend_d, else INST. Otherwise stay in IDLE.
  - Requests are sampled only in IDLE; later changes on the inputs are ignored until DONE.
- DATA: drive mem_addr from the latched data address.
  - Write: mem_write=1 and mem_wdata=latched wdata for exactly 1 cycle. Next state INST if pend_i, else DONE.
  - Read: mem_read=1 for exactly 1 cycle, load counter=READ_LAT. Next state WAIT_D.
- WAIT_D:
  - Strobes low; counter decrements each cycle.
  - On the cycle the counter equals 1, capture mem_rdata into dm_rdata.
  - Next state INST if pend_i, else DONE.
- INST / WAIT_I: same sequence as a data read, using the latched fetch address; the result is captured into if_rdata.
- DONE: stall=0, done=1 for one cycle; requests are ignored. Next state IDLE.
- Priority: data before fetch, always. A pipeline-wide stall means the older instruction completes first; no starvation is possible because both pending requests are drained in every window.
- Cycle cost with READ_LAT=1: overhead 1 (IDLE) + 1 (DONE), plus per read 2 cycles and per write 1 cycle.
- Output holding: if_rdata/dm_rdata hold their value until overwritten by a later capture. A port not requested in a window keeps its old value.
- dm_rd and dm_wr high together is illegal; write wins and no read is issued.
- Address and data widths pass straight through; no alignment check or byte enables (word accesses only).
- mem_read and mem_write are never high in the same cycle, and each is never high for more than one consecutive cycle.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encoding constants (3-bit: IDLE=0, DATA=1, WAIT_D=2, INST=3, WAIT_I=4, DONE=5).
  - Operation encoding (OP_RD=0, OP_WR=1).
  - The READ_LAT legal-range constant.
- Natural sub-module: mem_arb_port_seq, a read-issue/wait/capture sequencer (strobe, latency counter, capture enable). It is instantiated twice, for the data and fetch paths; the top holds the FSM and output muxing.

Test Plan:
- Fetch only: if_req=1, if_addr=0x00000040, memory word 0x20080005, READ_LAT=1 -> stall high cycles 0-2; mem_read pulses in cycle 1; done=1 and if_rdata=0x20080005 in cycle 3.
- Load + fetch together: dm_rd=1, dm_addr=0x100 (0xDEADBEEF), if_addr=0x44 (0x8C090100) -> mem_read at cycles 1 (addr 0x100) and 3 (addr 0x44); done at cycle 5 with dm_rdata=0xDEADBEEF and if_rdata=0x8C090100.
- Store + fetch: dm_wr=1, dm_addr=0x200, dm_wdata=0x12345678, if_addr=0x48 -> mem_write one cycle at cycle 1; mem_read at cycle 2; done at cycle 4; a subsequent read of 0x200 returns 0x12345678.
- READ_LAT=3, fetch only -> mem_read at cycle 1; capture at cycle 4; done at cycle 5; mem_rdata changes before cycle 4 are not captured.
- Reset mid-transaction: pull reset_n low during WAIT_D of a load+fetch window -> all outputs 0 immediately; after release with requests low, no strobes are issued and stall=0.
- Illegal dm_rd=dm_wr=1 with if_req=0 -> exactly one mem_write and no mem_read; done at cycle 2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StData  = 3'd1,
    StWaitD = 3'd2,
    StInst  = 3'd3,
    StWaitI = 3'd4,
    StDone  = 3'd5
  } arb_state_e;

  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } arb_op_e;

  localparam int unsigned ReadLatMin = 1;
  localparam int unsigned ReadLatMax = 15;
  localparam int unsigned LatCntW    = 4;

  // Out-of-range latencies are pinned to the nearest legal value.
  function automatic logic [LatCntW-1:0] clamp_read_lat(input int unsigned lat);
    if (lat < ReadLatMin) return LatCntW'(ReadLatMin);
    if (lat > ReadLatMax) return LatCntW'(ReadLatMax);
    return LatCntW'(lat);
  endfunction

endpackage

// File: rtl/mem_arb_port_seq.sv
// Read sequencer for one arbiter port: strobe, latency countdown, result capture.
module mem_arb_port_seq
  import mem_arb_pkg::*;
#(
  parameter int unsigned DataW   = 32,
  parameter int unsigned ReadLat = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [DataW-1:0] rdata_i,
  output logic             strobe_o,
  output logic             last_o,
  output logic [DataW-1:0] data_o
);

  localparam logic [LatCntW-1:0] LatInit = clamp_read_lat(ReadLat);

  logic               strobe_q;
  logic [LatCntW-1:0] cnt_q, cnt_d;
  logic [DataW-1:0]   data_q, data_d;

  // Counter is loaded at the end of the strobe cycle; data is valid when it reads 1.
  assign last_o = (cnt_q == LatCntW'(1));

  // Next-state for the latency counter and the held result.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (strobe_q) begin
      cnt_d = LatInit;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LatCntW'(1);
    end
    if (last_o) begin
      data_d = rdata_i;
    end
  end

  // Sequencer state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strobe_q <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      strobe_q <= start_i;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  assign strobe_o = strobe_q;
  assign data_o   = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port arbiter between fetch and data ports; stalls the pipeline per window.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  arb_op_e           op_q;
  logic              pend_i_q;
  logic [ADDR_W-1:0] daddr_q, iaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_write_q, done_q;

  logic any_req, d_start, w_start, i_start;
  logic d_strobe, i_strobe, d_last, i_last;

  assign any_req = if_req | dm_rd | dm_wr;

  // Strobes are registered, so they are launched on entry to DATA / INST.
  // A simultaneous rd+wr is treated as a write only.
  assign d_start = (state_q == StIdle) && dm_rd && !dm_wr;
  assign w_start = (state_q == StIdle) && dm_wr;
  assign i_start = (state_d == StInst) && (state_q != StInst);

  // Next state: data side is always drained before the fetch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = (dm_rd || dm_wr) ? StData : StInst;
      StData:  state_d = (op_q == OpWr) ? (pend_i_q ? StInst : StDone) : StWaitD;
      StWaitD: if (d_last) state_d = pend_i_q ? StInst : StDone;
      StInst:  state_d = StWaitI;
      StWaitI: if (i_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state, request latches and registered write/done outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      op_q        <= OpRd;
      pend_i_q    <= 1'b0;
      daddr_q     <= '0;
      iaddr_q     <= '0;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && any_req) begin
        op_q     <= dm_wr ? OpWr : OpRd;
        pend_i_q <= if_req;
        daddr_q  <= dm_addr;
        iaddr_q  <= if_addr;
        wdata_q  <= dm_wdata;
      end
      mem_write_q <= w_start;
      done_q      <= (state_d == StDone);
    end
  end

  mem_arb_port_seq #(
    .DataW  (DATA_W),
    .ReadLat(READ_LAT)
  ) u_data_seq (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .start_i (d_start),
    .rdata_i (mem_rdata),
    .strobe_o(d_strobe),
    .last_o  (d_last),
    .data_o  (dm_rdata)
  );

  mem_arb_port_seq #(
    .DataW  (DATA_W),
    .ReadLat(READ_LAT)
  ) u_inst_seq (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .start_i (i_start),
    .rdata_i (mem_rdata),
    .strobe_o(i_strobe),
    .last_o  (i_last),
    .data_o  (if_rdata)
  );

  // Memory address follows whichever side owns the port in the current state.
  always_comb begin
    unique case (state_q)
      StData, StWaitD: mem_addr = daddr_q;
      StInst, StWaitI: mem_addr = iaddr_q;
      default:         mem_addr = '0;
    endcase
  end

  assign mem_read  = d_strobe | i_strobe;
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_write_q ? wdata_q : '0;
  assign done      = done_q;
  assign stall     = ((state_q == StIdle) && any_req) ||
                     ((state_q != StIdle) && (state_q != StDone));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: two arbiters (READ_LAT 1 and 3) share stimulus, each with its own memory.
module tb_mem_arbiter;

  typedef struct {
    int          t0;
    int          lat;
    logic [31:0] if_exp;
    logic [31:0] dm_exp;
  } win_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } stb_t;

  logic        clock, reset_n;
  logic        if_req, dm_rd, dm_wr;
  logic [31:0] if_addr, dm_addr, dm_wdata;

  logic [31:0] if_rdata [2];
  logic [31:0] dm_rdata [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        stall [2];
  logic        done [2];
  logic        mem_read [2];
  logic        mem_write [2];

  logic [31:0] mem [2][1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] dl_d [2][3];
  logic        dl_v [2][3];
  logic [31:0] junk [2];
  logic        rd_prev [2];
  logic        wr_prev [2];
  logic        mem_load;

  logic [31:0] ref_if, ref_dm;
  win_t        win_q [2][$];
  stb_t        stb_q [2][$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) u_dut_l1 (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[0]),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata[0]), .stall(stall[0]), .done(done[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_read(mem_read[0]),
    .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0])
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3)) u_dut_l3 (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[1]),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata[1]), .stall(stall[1]), .done(done[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_read(mem_read[1]),
    .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory models: read data appears exactly READ_LAT cycles after the strobe, junk otherwise.
  assign mem_rdata[0] = dl_v[0][0] ? dl_d[0][0] : junk[0];
  assign mem_rdata[1] = dl_v[1][2] ? dl_d[1][2] : junk[1];

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      junk[k]     <= $urandom();
      dl_v[k][0]  <= mem_read[k];
      dl_d[k][0]  <= mem[k][mem_addr[k][11:2]];
      dl_v[k][1]  <= dl_v[k][0];
      dl_d[k][1]  <= dl_d[k][0];
      dl_v[k][2]  <= dl_v[k][1];
      dl_d[k][2]  <= dl_d[k][1];
      if (mem_write[k]) mem[k][mem_addr[k][11:2]] <= mem_wdata[k];
      if (mem_load) begin
        for (int i = 0; i < 1024; i++) mem[k][i] <= ref_mem[i];
      end
    end
  end

  // Monitor: stall, strobe trace and release results against the scoreboard.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      win_t w;
      stb_t s;
      logic exp_stall;
      exp_stall = 1'b0;
      if (win_q[k].size() != 0) exp_stall = ((cyc - win_q[k][0].t0) != win_q[k][0].lat);
      check_eq($sformatf("stall[%0d]", k), {31'd0, stall[k]}, {31'd0, exp_stall});
      check_eq($sformatf("strobe_excl[%0d]", k), {31'd0, mem_read[k] & mem_write[k]}, 32'd0);
      check_eq($sformatf("strobe_run[%0d]", k),
               {31'd0, (mem_read[k] & rd_prev[k]) | (mem_write[k] & wr_prev[k])}, 32'd0);
      rd_prev[k] <= mem_read[k];
      wr_prev[k] <= mem_write[k];
      if (mem_read[k] || mem_write[k]) begin
        if (stb_q[k].size() == 0) begin
          check_eq($sformatf("strobe_unexpected[%0d]", k), {30'd0, mem_read[k], mem_write[k]},
                   32'd0);
        end else begin
          s = stb_q[k].pop_front();
          check_eq($sformatf("strobe_cycle[%0d]", k), cyc, s.cyc);
          check_eq($sformatf("strobe_kind[%0d]", k), {31'd0, mem_write[k]}, {31'd0, s.wr});
          check_eq($sformatf("strobe_addr[%0d]", k), mem_addr[k], s.addr);
          if (s.wr) check_eq($sformatf("strobe_wdata[%0d]", k), mem_wdata[k], s.wdata);
        end
      end
      if (done[k]) begin
        if (win_q[k].size() == 0) begin
          check_eq($sformatf("done_unexpected[%0d]", k), {31'd0, done[k]}, 32'd0);
        end else begin
          w = win_q[k].pop_front();
          check_eq($sformatf("done_cycle[%0d]", k), cyc - w.t0, w.lat);
          check_eq($sformatf("if_rdata[%0d]", k), if_rdata[k], w.if_exp);
          check_eq($sformatf("dm_rdata[%0d]", k), dm_rdata[k], w.dm_exp);
          check_eq($sformatf("strobe_missing[%0d]", k), stb_q[k].size(), 32'd0);
        end
      end
    end
  end

  // Drive one request window and push the expected trace for both instances.
  task automatic issue(input logic ifr, input logic [31:0] ia, input logic rd, input logic wr,
                       input logic [31:0] da, input logic [31:0] wd);
    win_t w;
    stb_t s;
    int   off;
    @(posedge clock);
    #1;
    if_req = ifr; if_addr = ia; dm_rd = rd; dm_wr = wr; dm_addr = da; dm_wdata = wd;
    if (wr) ref_mem[da[11:2]] = wd;
    else if (rd) ref_dm = ref_mem[da[11:2]];
    if (ifr) ref_if = ref_mem[ia[11:2]];
    for (int k = 0; k < 2; k++) begin
      off = 1;
      if (rd || wr) begin
        s.cyc = cyc + 1; s.wr = wr; s.addr = da; s.wdata = wd;
        stb_q[k].push_back(s);
        off += wr ? 1 : 1 + lat_of(k);
      end
      if (ifr) begin
        s.cyc = cyc + off; s.wr = 1'b0; s.addr = ia; s.wdata = 32'd0;
        stb_q[k].push_back(s);
        off += 1 + lat_of(k);
      end
      w.t0 = cyc; w.lat = off; w.if_exp = ref_if; w.dm_exp = ref_dm;
      win_q[k].push_back(w);
    end
  endtask

  // Requests drop after the first cycle; address/data lines carry junk that must be ignored.
  task automatic drain();
    int budget;
    budget = 0;
    while ((win_q[0].size() + win_q[1].size()) != 0 && budget < 40) begin
      @(posedge clock);
      #1;
      if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
      if_addr = $urandom(); dm_addr = $urandom(); dm_wdata = $urandom();
      budget++;
    end
    check_eq("window_drained", win_q[0].size() + win_q[1].size(), 32'd0);
    for (int k = 0; k < 2; k++) begin
      win_q[k].delete();
      stb_q[k].delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_if_rdata[%0d]", tag, k), if_rdata[k], 32'd0);
      check_eq($sformatf("%s_dm_rdata[%0d]", tag, k), dm_rdata[k], 32'd0);
      check_eq($sformatf("%s_mem_addr[%0d]", tag, k), mem_addr[k], 32'd0);
      check_eq($sformatf("%s_mem_wdata[%0d]", tag, k), mem_wdata[k], 32'd0);
      check_eq($sformatf("%s_ctrl[%0d]", tag, k),
               {28'd0, done[k], mem_read[k], mem_write[k], stall[k]}, 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  r;
    logic [31:0] ra, rb;
    reset_n = 1'b0; mem_load = 1'b1;
    if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    ref_if = '0; ref_dm = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0101);
    ref_mem[32'h40 >> 2]  = 32'h2008_0005;
    ref_mem[32'h44 >> 2]  = 32'h8C09_0100;
    ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      rd_prev[k] = 1'b0; wr_prev[k] = 1'b0;
      for (int j = 0; j < 3; j++) begin
        dl_v[k][j] = 1'b0; dl_d[k][j] = '0;
      end
    end
    repeat (2) @(posedge clock);
    #1;
    mem_load = 1'b0;
    check_cleared("reset");
    reset_n = 1'b1;

    issue(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);                 // fetch only
    drain();
    issue(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0);               // load + fetch
    drain();
    issue(1'b1, 32'h48, 1'b0, 1'b1, 32'h200, 32'h1234_5678);       // store + fetch
    drain();
    issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);                // load back the store
    drain();
    issue(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'hCAFE_F00D);        // illegal rd+wr
    drain();
    issue(1'b1, 32'h300, 1'b1, 1'b0, 32'h300, 32'h0);              // load + fetch same word
    drain();
    issue(1'b1, 32'h304, 1'b0, 1'b1, 32'h304, 32'h0BAD_F00D);      // fetch sees fresh store
    drain();

    for (int n = 0; n < 16; n++) begin
      r  = 3'($urandom_range(1, 7));
      ra = {20'd0, 10'($urandom()), 2'b00};
      rb = {20'd0, 10'($urandom()), 2'b00};
      issue(r[0], ra, r[1], r[2], rb, $urandom());
      drain();
    end

    // Abort a load+fetch window while both instances sit in WAIT_D.
    issue(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0);
    @(posedge clock);
    #1;
    if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      win_q[k].delete();
      stb_q[k].delete();
    end
    reset_n = 1'b0;
    #1;
    check_cleared("midreset");
    ref_if = '0; ref_dm = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check_cleared("postreset");

    issue(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0);
    drain();

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
